// File: rtl/ddr3_req_arbiter_pkg.sv
// Shared definitions for the DDR3 request arbiter.
// Command direction encodings and arbiter lock states.
package ddr3_req_arbiter_pkg;

    localparam logic CMD_RD = 1'b1;
    localparam logic CMD_WR = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_LOCK = 2'd1,
        ST_WR_LOCK = 2'd2
    } arb_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ddr3_req_arbiter.sv
// Merges AXI write/read request ports into one registered DDR3 command
// stream; read-preferred with sequence locking and write-starvation bound.
module ddr3_req_arbiter
    import ddr3_req_arbiter_pkg::*;
#(
    parameter int ADDRS        = 32,
    parameter int MEM_ID_WIDTH = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_req_i,
    output logic                    wr_ack_o,
    input  logic                    wr_lst_i,
    input  logic [MEM_ID_WIDTH-1:0] wr_tid_i,
    input  logic [ADDRS-1:0]        wr_adr_i,
    input  logic                    rd_req_i,
    output logic                    rd_ack_o,
    input  logic                    rd_lst_i,
    input  logic [MEM_ID_WIDTH-1:0] rd_tid_i,
    input  logic [ADDRS-1:0]        rd_adr_i,
    output logic                    ctl_req_o,
    input  logic                    ctl_ack_i,
    output logic                    ctl_rdwr_o,
    output logic                    ctl_lst_o,
    output logic [MEM_ID_WIDTH-1:0] ctl_tid_o,
    output logic [ADDRS-1:0]        ctl_adr_o
);

    arb_state_e              state_q, state_d;
    logic [7:0]              starve_q, starve_d;
    logic                    ctl_req_q, ctl_rdwr_q, ctl_lst_q;
    logic [MEM_ID_WIDTH-1:0] ctl_tid_q;
    logic [ADDRS-1:0]        ctl_adr_q;

    logic slot_free, wr_wins, grant_rd, grant_wr;

    assign slot_free = ~ctl_req_q | ctl_ack_i;
    assign wr_wins   = starve_q >= 8'(STARVE_LIMIT);

    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        unique case (state_q)
            ST_RD_LOCK: grant_rd = rd_req_i;
            ST_WR_LOCK: grant_wr = wr_req_i;
            default: begin
                grant_rd = rd_req_i & (~wr_req_i | ~wr_wins);
                grant_wr = wr_req_i & (~rd_req_i | wr_wins);
            end
        endcase
    end

    assign rd_ack_o = ~reset & slot_free & grant_rd;
    assign wr_ack_o = ~reset & slot_free & grant_wr;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (rd_ack_o) begin
            state_d = rd_lst_i ? ST_IDLE : ST_RD_LOCK;
            if (wr_req_i)
                starve_d = sat_inc8(starve_q);
        end else if (wr_ack_o) begin
            state_d  = wr_lst_i ? ST_IDLE : ST_WR_LOCK;
            starve_d = 8'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            starve_q   <= 8'd0;
            ctl_req_q  <= 1'b0;
            ctl_rdwr_q <= 1'b0;
            ctl_lst_q  <= 1'b0;
            ctl_tid_q  <= '0;
            ctl_adr_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if (rd_ack_o) begin
                ctl_req_q  <= 1'b1;
                ctl_rdwr_q <= CMD_RD;
                ctl_lst_q  <= rd_lst_i;
                ctl_tid_q  <= rd_tid_i;
                ctl_adr_q  <= rd_adr_i;
            end else if (wr_ack_o) begin
                ctl_req_q  <= 1'b1;
                ctl_rdwr_q <= CMD_WR;
                ctl_lst_q  <= wr_lst_i;
                ctl_tid_q  <= wr_tid_i;
                ctl_adr_q  <= wr_adr_i;
            end else if (ctl_ack_i) begin
                // Payload is left as-is; only valid drops once consumed.
                ctl_req_q <= 1'b0;
            end
        end
    end

    assign ctl_req_o  = ctl_req_q;
    assign ctl_rdwr_o = ctl_rdwr_q;
    assign ctl_lst_o  = ctl_lst_q;
    assign ctl_tid_o  = ctl_tid_q;
    assign ctl_adr_o  = ctl_adr_q;

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// Randomized scoreboard bench for ddr3_req_arbiter with a
// behavioural grant model and decoupled output monitor.
module tb_ddr3_req_arbiter;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_req, wr_ack, wr_lst;
    logic [3:0]  wr_tid;
    logic [31:0] wr_adr;
    logic        rd_req, rd_ack, rd_lst;
    logic [3:0]  rd_tid;
    logic [31:0] rd_adr;
    logic        ctl_req, ctl_ack, ctl_rdwr, ctl_lst;
    logic [3:0]  ctl_tid;
    logic [31:0] ctl_adr;

    always #5 clk = ~clk;

    ddr3_req_arbiter #(
        .ADDRS(32), .MEM_ID_WIDTH(4), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock(clk), .reset(reset),
        .wr_req_i(wr_req), .wr_ack_o(wr_ack), .wr_lst_i(wr_lst),
        .wr_tid_i(wr_tid), .wr_adr_i(wr_adr),
        .rd_req_i(rd_req), .rd_ack_o(rd_ack), .rd_lst_i(rd_lst),
        .rd_tid_i(rd_tid), .rd_adr_i(rd_adr),
        .ctl_req_o(ctl_req), .ctl_ack_i(ctl_ack), .ctl_rdwr_o(ctl_rdwr),
        .ctl_lst_o(ctl_lst), .ctl_tid_o(ctl_tid), .ctl_adr_o(ctl_adr)
    );

    typedef struct {
        bit        rd;
        bit        lst;
        bit [3:0]  tid;
        bit [31:0] adr;
    } cmd_t;

    cmd_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: owner of the current sequence (0 none, 1 read, 2 write),
    // number of reads granted over a waiting write, slot occupancy.
    int   owner  = 0;
    int   starve = 0;
    bit   occ    = 0;
    int   g;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit wq, input bit wl,
                        input bit rq, input bit rl, input bit ai,
                        input bit [3:0] wt, input bit [3:0] rt,
                        input bit [31:0] wa, input bit [31:0] ra);
        bit room, er, ew;
        cmd_t c;
        @(negedge clk);
        reset = rst; ctl_ack = ai;
        wr_req = wq; wr_lst = wl; wr_tid = wt; wr_adr = wa;
        rd_req = rq; rd_lst = rl; rd_tid = rt; rd_adr = ra;
        #1;
        room = !occ || ai;
        er = 0; ew = 0;
        if (!rst && room) begin
            if (owner == 1) er = rq;
            else if (owner == 2) ew = wq;
            else if (rq && wq) begin
                if (starve >= LIMIT) ew = 1; else er = 1;
            end else begin
                er = rq; ew = wq;
            end
        end
        chk("rd_ack", 32'(rd_ack), 32'(er));
        chk("wr_ack", 32'(wr_ack), 32'(ew));
        g = er ? 1 : ew ? 2 : 0;
        if (rst) begin
            owner = 0; starve = 0; occ = 0;
            q.delete();
        end else begin
            if (er) begin
                c.rd = 1; c.lst = rl; c.tid = rt; c.adr = ra;
                q.push_back(c);
                owner = rl ? 0 : 1;
                if (wq && starve < 255) starve++;
            end else if (ew) begin
                c.rd = 0; c.lst = wl; c.tid = wt; c.adr = wa;
                q.push_back(c);
                owner = wl ? 0 : 2;
                starve = 0;
            end
            if (er || ew) occ = 1;
            else if (ai) occ = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    endtask

    // Monitor: consumes commands as the controller takes them and
    // checks the slot is frozen while the controller stalls.
    bit          hold = 0;
    logic [37:0] held;
    always begin
        cmd_t e;
        logic [37:0] now;
        @(negedge clk);
        #3;
        now = {ctl_req, ctl_rdwr, ctl_lst, ctl_tid, ctl_adr};
        if (reset) begin
            hold = 0;
        end else begin
            if (hold) begin
                checks++;
                if (now !== held) begin
                    errors++;
                    $display("FAIL stall_stable: got %0h expected %0h",
                             now, held);
                end
            end
            if (ctl_req && ctl_ack) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_cmd: got %0h expected none",
                             now);
                end else begin
                    e = q.pop_front();
                    if ({ctl_rdwr, ctl_lst, ctl_tid, ctl_adr} !==
                        {e.rd, e.lst, e.tid, e.adr}) begin
                        errors++;
                        $display("FAIL cmd: got %0h expected %0h",
                                 {ctl_rdwr, ctl_lst, ctl_tid, ctl_adr},
                                 {e.rd, e.lst, e.tid, e.adr});
                    end
                end
            end
            hold = ctl_req && !ctl_ack;
            held = now;
        end
    end

    initial begin
        reset = 1; ctl_ack = 0;
        wr_req = 0; wr_lst = 0; wr_tid = 0; wr_adr = 0;
        rd_req = 0; rd_lst = 0; rd_tid = 0; rd_adr = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state and single read with latency 1
        step(0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        chk("reset_req", 32'(ctl_req), 0);
        chk("reset_adr", ctl_adr, 0);
        chk("reset_tid", 32'(ctl_tid), 0);
        step(0, 0, 1, 1, 1, 0, 0, 3, 0, 32'h100);
        step(0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        chk("rd1_req", 32'(ctl_req), 1);
        chk("rd1_rdwr", 32'(ctl_rdwr), 1);
        chk("rd1_tid", 32'(ctl_tid), 3);
        chk("rd1_adr", ctl_adr, 32'h100);
        idle(2);

        // Locked read sequence holds off a waiting write
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 1, i == 3, 1, 4'd9, 4'(i), 32'hA000,
                 32'h200 + 32'(i));
            chk("seq_grant_rd", 32'(g), 1);
        end
        step(0, 1, 1, 0, 1, 1, 4'd9, 0, 32'hA000, 0);
        chk("seq_grant_wr", 32'(g), 2);
        idle(2);

        // Starvation pattern: 8 reads then 1 write
        for (int i = 0; i < 27; i++) begin
            step(0, 1, 1, 1, 1, 1, 4'(i), 4'(i), 32'(i), 32'(i) + 32'h8000);
            chk("starve_pattern", 32'(g), (i % 9 == 8) ? 2 : 1);
        end
        idle(2);

        // Controller stall keeps slot stable and blocks acks
        step(0, 1, 1, 0, 1, 0, 4'd5, 0, 32'hBEEF, 0);
        for (int i = 0; i < 5; i++)
            step(0, 0, 1, 1, 1, 0, 0, 4'd6, 0, 32'hCAFE);
        step(0, 0, 1, 1, 1, 1, 0, 4'd6, 0, 32'hCAFE);
        chk("stall_release", 32'(g), 1);
        idle(2);

        // Reset in the middle of a locked write sequence
        step(0, 1, 0, 0, 1, 1, 4'd7, 0, 32'h300, 0);
        step(0, 0, 1, 1, 1, 1, 0, 4'd2, 0, 32'h400);
        chk("wrlock_blocks_rd", 32'(g), 0);
        step(1, 1, 1, 1, 1, 0, 4'd7, 4'd2, 32'h304, 32'h400);
        step(0, 1, 1, 1, 1, 1, 4'd7, 4'd2, 32'h304, 32'h400);
        chk("post_reset_req", 32'(ctl_req), 0);
        chk("post_reset_adr", ctl_adr, 0);
        chk("post_reset_grant", 32'(g), 1);
        idle(3);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(499) == 0,
                 $urandom_range(1) == 1, $urandom_range(2) == 0,
                 $urandom_range(1) == 1, $urandom_range(2) == 0,
                 $urandom_range(9) < 7,
                 4'($urandom), 4'($urandom), $urandom, $urandom);
        end
        idle(4);
        chk("drain_empty", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
